// File: rtl/uart_expr_pkg.sv
// Shared encodings for the UART expression front-end: FSM states, ASCII codes and ALU opcodes.
package uart_expr_pkg;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_OP   = 3'd1,
      S_B    = 3'd2,
      S_CONV = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [7:0] ASC_ENTER = 8'h0D;
   localparam logic [7:0] ASC_NEG   = 8'h6E;
   localparam logic [7:0] ASC_0     = 8'h30;
   localparam logic [7:0] ASC_9     = 8'h39;
   localparam logic [7:0] ASC_PLUS  = 8'h2B;
   localparam logic [7:0] ASC_MINUS = 8'h2D;
   localparam logic [7:0] ASC_MUL   = 8'h2A;
   localparam logic [7:0] ASC_DIV   = 8'h2F;
   localparam logic [7:0] ASC_BS    = 8'h08;
   localparam logic [7:0] ASC_DEL   = 8'h7F;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/uart_rx_edge.sv
// Two-flop synchronizer for the UART byte-ready level plus a single-cycle rising-edge pulse.
module uart_rx_edge (
   input  logic clk,
   input  logic reset,
   input  logic received,
   output logic pulse
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
      end else begin
         sync1_reg <= received;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   assign pulse = sync2_reg & ~prev_reg;

endmodule

// File: rtl/uart_expr_parser.sv
// Parses "A <Enter> op <Enter> B <Enter>" from UART bytes and converts BCD operands serially.
// Backspace editing is compiled in only when UART_BACKSPACE_EN is defined.
module uart_expr_parser
   import uart_expr_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              data,
   input  logic                    received,
   output logic signed [WIDTH-1:0] A,
   output logic signed [WIDTH-1:0] B,
   output logic [1:0]              alu_ops,
   output logic [2:0]              st,
   output logic                    done,
   output logic                    busy,
   output logic                    err
);

   localparam int BUF_W = 4 * MAX_DIGITS;
   localparam int ACC_W = (WIDTH + 1 > 34) ? WIDTH + 1 : 34;
   localparam int CNT_W = 4;
   localparam int IDX_W = 5;
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [ACC_W-1:0] MAX_MAG = ACC_W'(MAX_POS);

   state_t           state_reg;
   logic [BUF_W-1:0] buf_reg [2];
   logic [CNT_W-1:0] cnt_reg [2];
   logic             neg_reg [2];
   logic [1:0]       op_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [ACC_W-1:0] acc_reg;
   logic [ACC_W-1:0] a_mag_reg;

   logic             byte_evt;
   logic             is_digit;
   logic             is_bs;
   logic             sel;

   uart_rx_edge u_edge (
      .clk      (clk),
      .reset    (reset),
      .received (received),
      .pulse    (byte_evt)
   );

   assign is_digit = (data >= ASC_0) && (data <= ASC_9);
   assign sel      = (state_reg == S_B);

`ifdef UART_BACKSPACE_EN
   assign is_bs = (data == ASC_BS) || (data == ASC_DEL);
`else
   assign is_bs = 1'b0;
`endif

   // One shared x10 adder walks A's digits then B's, MSD first; leading zero nibbles are harmless.
   logic             conv_b;
   logic             conv_last;
   logic [3:0]       conv_digit;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W-1:0] acc_sum;

   assign conv_b     = idx_reg >= IDX_W'(MAX_DIGITS);
   assign conv_last  = idx_reg == IDX_W'(2 * MAX_DIGITS);
   assign conv_digit = buf_reg[conv_b][BUF_W-1 -: 4];
   assign acc_base   = (idx_reg == '0 || idx_reg == IDX_W'(MAX_DIGITS)) ? '0 : acc_reg;
   assign acc_sum    = (acc_base << 3) + (acc_base << 1) + ACC_W'(conv_digit);

   logic [ACC_W-1:0] mag  [2];
   logic             over [2];
   logic [WIDTH-1:0] res  [2];

   assign mag[0] = a_mag_reg;
   assign mag[1] = acc_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_sat
      assign over[gi] = mag[gi] > MAX_MAG;
      assign res[gi]  = over[gi] ? (neg_reg[gi] ? -MAX_POS : MAX_POS)
                                 : (neg_reg[gi] ? -mag[gi][WIDTH-1:0] : mag[gi][WIDTH-1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= S_A;
         buf_reg[0] <= '0;
         buf_reg[1] <= '0;
         cnt_reg[0] <= '0;
         cnt_reg[1] <= '0;
         neg_reg[0] <= 1'b0;
         neg_reg[1] <= 1'b0;
         op_reg     <= OP_ADD;
         idx_reg    <= '0;
         acc_reg    <= '0;
         a_mag_reg  <= '0;
         A          <= '0;
         B          <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_A, S_B: begin
               if (byte_evt) begin
                  if (is_digit) begin
                     if (cnt_reg[sel] < CNT_W'(MAX_DIGITS)) begin
                        buf_reg[sel] <= (buf_reg[sel] << 4) | BUF_W'(data[3:0]);
                        cnt_reg[sel] <= cnt_reg[sel] + 1'b1;
                     end
                  end else if (data == ASC_NEG) begin
                     if (cnt_reg[sel] == '0) neg_reg[sel] <= ~neg_reg[sel];
                  end else if (data == ASC_ENTER) begin
                     if (sel) begin
                        state_reg <= S_CONV;
                        busy      <= 1'b1;
                        idx_reg   <= '0;
                     end else begin
                        state_reg <= S_OP;
                     end
                  end else if (is_bs) begin
                     if (cnt_reg[sel] != '0) begin
                        buf_reg[sel] <= buf_reg[sel] >> 4;
                        cnt_reg[sel] <= cnt_reg[sel] - 1'b1;
                     end else begin
                        neg_reg[sel] <= 1'b0;
                     end
                  end
               end
            end
            S_OP: begin
               if (byte_evt) begin
                  if (data == ASC_PLUS)       op_reg <= OP_ADD;
                  else if (data == ASC_MINUS) op_reg <= OP_SUB;
                  else if (data == ASC_MUL)   op_reg <= OP_MUL;
                  else if (data == ASC_DIV)   op_reg <= OP_DIV;
                  else if (data == ASC_ENTER) state_reg <= S_B;
                  else if (is_bs)             op_reg <= OP_ADD;
               end
            end
            S_CONV: begin
               if (byte_evt) err <= 1'b1;
               acc_reg         <= acc_sum;
               buf_reg[conv_b] <= buf_reg[conv_b] << 4;
               idx_reg         <= idx_reg + 1'b1;
               if (idx_reg == IDX_W'(MAX_DIGITS - 1)) a_mag_reg <= acc_sum;
               if (conv_last) begin
                  A         <= res[0];
                  B         <= res[1];
                  if (over[0] || over[1]) err <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               if (byte_evt && data == ASC_ENTER) begin
                  buf_reg[0] <= '0;
                  buf_reg[1] <= '0;
                  cnt_reg[0] <= '0;
                  cnt_reg[1] <= '0;
                  neg_reg[0] <= 1'b0;
                  neg_reg[1] <= 1'b0;
                  op_reg     <= OP_ADD;
                  state_reg  <= S_A;
               end
            end
            default: state_reg <= S_A;
         endcase
      end
   end

   assign st      = state_reg;
   assign alu_ops = op_reg;

endmodule

// File: tb/tb_uart_expr_parser.sv
// Randomised bench for uart_expr_parser: two instances (16b/4 digits and 8b/3 digits) share one byte stream.
module tb_uart_expr_parser;

   logic clk = 1'b0;
   logic reset;
   logic received;
   logic [7:0] data;

   logic signed [15:0] a0, b0;
   logic signed [7:0]  a1, b1;
   logic [1:0] ops0, ops1;
   logic [2:0] st0, st1;
   logic done0, done1, busy0, busy1, err0, err1;

   always #5 clk = ~clk;

   uart_expr_parser #(.WIDTH(16), .MAX_DIGITS(4)) dut0 (
      .clk(clk), .reset(reset), .data(data), .received(received),
      .A(a0), .B(b0), .alu_ops(ops0), .st(st0), .done(done0), .busy(busy0), .err(err0)
   );

   uart_expr_parser #(.WIDTH(8), .MAX_DIGITS(3)) dut1 (
      .clk(clk), .reset(reset), .data(data), .received(received),
      .A(a1), .B(b1), .alu_ops(ops1), .st(st1), .done(done1), .busy(busy1), .err(err1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint obs_a(input int i);    return (i == 0) ? longint'(a0) : longint'(a1); endfunction
   function automatic longint obs_b(input int i);    return (i == 0) ? longint'(b0) : longint'(b1); endfunction
   function automatic longint obs_ops(input int i);  return (i == 0) ? longint'(ops0) : longint'(ops1); endfunction
   function automatic longint obs_st(input int i);   return (i == 0) ? longint'(st0) : longint'(st1); endfunction
   function automatic longint obs_done(input int i); return (i == 0) ? longint'(done0) : longint'(done1); endfunction
   function automatic longint obs_busy(input int i); return (i == 0) ? longint'(busy0) : longint'(busy1); endfunction
   function automatic longint obs_err(input int i);  return (i == 0) ? longint'(err0) : longint'(err1); endfunction

   // Monitor: length of each busy run, and outputs captured during each done pulse.
   int     run_len  [2] = '{0, 0};
   int     conv_len [2] = '{0, 0};
   int     done_cnt [2] = '{0, 0};
   longint done_a   [2];
   longint done_b   [2];
   longint done_ops [2];
   longint done_st  [2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (obs_busy(i) != 0) begin
            run_len[i] <= run_len[i] + 1;
         end else if (run_len[i] != 0) begin
            conv_len[i] <= run_len[i];
            run_len[i]  <= 0;
         end
         if (obs_done(i) != 0) begin
            done_cnt[i] <= done_cnt[i] + 1;
            done_a[i]   <= obs_a(i);
            done_b[i]   <= obs_b(i);
            done_ops[i] <= obs_ops(i);
            done_st[i]  <= obs_st(i);
         end
      end
   end

   // Reference model: phase 0=A,1=op,2=B,3=converting,4=done; digits kept as plain integer lists.
   int     md     [2] = '{4, 3};
   longint maxv   [2] = '{32767, 127};
   int     ph     [2];
   int     digs   [2][2][10];
   int     cnt    [2][2];
   bit     neg    [2][2];
   int     mop    [2];
   bit     merr   [2];
   longint ea     [2];
   longint eb     [2];
   longint pa     [2];
   longint pb     [2];
   bit     psat   [2];
   int     base   [2];

   function automatic longint op_value(input int i, input int k, output bit sat);
      longint m = 0;
      for (int j = 0; j < cnt[i][k]; j++) m = m * 10 + digs[i][k][j];
      sat = (m > maxv[i]);
      if (sat) m = maxv[i];
      return neg[i][k] ? -m : m;
   endfunction

   task automatic model_clear(input int i);
      for (int k = 0; k < 2; k++) begin
         cnt[i][k] = 0;
         neg[i][k] = 1'b0;
      end
      mop[i] = 0;
      ph[i]  = 0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         model_clear(i);
         merr[i] = 1'b0;
         ea[i]   = 0;
         eb[i]   = 0;
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      int k;
      bit s0, s1;
      for (int i = 0; i < 2; i++) begin
         case (ph[i])
            0, 2: begin
               k = ph[i] / 2;
               if (b >= 8'h30 && b <= 8'h39) begin
                  if (cnt[i][k] < md[i]) begin
                     digs[i][k][cnt[i][k]] = int'(b) - 48;
                     cnt[i][k]++;
                  end
               end else if (b == 8'h6E) begin
                  if (cnt[i][k] == 0) neg[i][k] = !neg[i][k];
               end else if (b == 8'h0D) begin
                  if (k == 1) begin
                     pa[i]   = op_value(i, 0, s0);
                     pb[i]   = op_value(i, 1, s1);
                     psat[i] = s0 | s1;
                  end
                  ph[i]++;
               end
`ifdef UART_BACKSPACE_EN
               else if (b == 8'h08 || b == 8'h7F) begin
                  if (cnt[i][k] > 0) cnt[i][k]--;
                  else neg[i][k] = 1'b0;
               end
`endif
            end
            1: begin
               if (b == 8'h2B) mop[i] = 0;
               else if (b == 8'h2D) mop[i] = 1;
               else if (b == 8'h2A) mop[i] = 2;
               else if (b == 8'h2F) mop[i] = 3;
               else if (b == 8'h0D) ph[i] = 2;
`ifdef UART_BACKSPACE_EN
               else if (b == 8'h08 || b == 8'h7F) mop[i] = 0;
`endif
            end
            3: merr[i] = 1'b1;
            default: if (b == 8'h0D) model_clear(i);
         endcase
      end
   endtask

   // One byte event: received high two clocks, then at least three clocks low.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      data     = b;
      received = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      received = 1'b0;
      repeat (3) @(negedge clk);
      model_byte(b);
   endtask

   // '|' stands for Enter and '<' for backspace in directed strings.
   task automatic send_str(input string s);
      logic [7:0] c;
      for (int j = 0; j < s.len(); j++) begin
         c = s[j];
         if (c == "|") c = 8'h0D;
         else if (c == "<") c = 8'h08;
         send_byte(c);
      end
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_st%0d", tag, i), obs_st(i), 0);
         check($sformatf("%s_A%0d", tag, i), obs_a(i), 0);
         check($sformatf("%s_B%0d", tag, i), obs_b(i), 0);
         check($sformatf("%s_ops%0d", tag, i), obs_ops(i), 0);
         check($sformatf("%s_done%0d", tag, i), obs_done(i), 0);
         check($sformatf("%s_busy%0d", tag, i), obs_busy(i), 0);
         check($sformatf("%s_err%0d", tag, i), obs_err(i), 0);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic mark_base();
      @(negedge clk);
      for (int i = 0; i < 2; i++) base[i] = done_cnt[i];
   endtask

   task automatic finish_conv(input string tag);
      repeat (16) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         ea[i]   = pa[i];
         eb[i]   = pb[i];
         merr[i] = merr[i] | psat[i];
         ph[i]   = 4;
         check($sformatf("%s_pulses%0d", tag, i), done_cnt[i] - base[i], 1);
         check($sformatf("%s_convlen%0d", tag, i), conv_len[i], 2 * md[i] + 1);
         check($sformatf("%s_doneA%0d", tag, i), done_a[i], ea[i]);
         check($sformatf("%s_doneB%0d", tag, i), done_b[i], eb[i]);
         check($sformatf("%s_doneops%0d", tag, i), done_ops[i], mop[i]);
         check($sformatf("%s_donest%0d", tag, i), done_st[i], 4);
         check($sformatf("%s_st%0d", tag, i), obs_st(i), 4);
         check($sformatf("%s_err%0d", tag, i), obs_err(i), merr[i]);
         check($sformatf("%s_busy%0d", tag, i), obs_busy(i), 0);
      end
   endtask

   task automatic check_idle(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_st%0d", tag, i), obs_st(i), ph[i]);
         check($sformatf("%s_A%0d", tag, i), obs_a(i), ea[i]);
         check($sformatf("%s_B%0d", tag, i), obs_b(i), eb[i]);
         check($sformatf("%s_err%0d", tag, i), obs_err(i), merr[i]);
      end
   endtask

   logic [7:0] junk [7] = '{8'h20, 8'h41, 8'h7A, 8'h3D, 8'h00, 8'hFF, 8'h2E};
   logic [7:0] opch [4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};

   task automatic rand_item();
      int r;
      r = $urandom_range(0, 11);
      if (r <= 5 || r == 11) send_byte(8'h30 + 8'($urandom_range(0, 9)));
      else if (r <= 7)       send_byte(8'h6E);
      else if (r == 8)       send_byte(junk[$urandom_range(0, 6)]);
      else if (r == 9)       send_byte(($urandom_range(0, 1) == 0) ? 8'h08 : 8'h7F);
      else                   send_byte(opch[$urandom_range(0, 3)]);
   endtask

   task automatic rand_expr(input int n);
      mark_base();
      repeat ($urandom_range(0, 7)) rand_item();
      send_byte(8'h0D);
      repeat ($urandom_range(0, 3)) begin
         if ($urandom_range(0, 3) == 0) send_byte(($urandom_range(0, 1) == 0) ? 8'h08 : junk[$urandom_range(0, 6)]);
         else send_byte(opch[$urandom_range(0, 3)]);
      end
      send_byte(8'h0D);
      check_idle($sformatf("r%0d_inB", n));
      repeat ($urandom_range(0, 7)) rand_item();
      send_byte(8'h0D);
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)));
      finish_conv($sformatf("r%0d", n));
      if ($urandom_range(0, 1) == 0) send_byte(junk[$urandom_range(0, 6)]);
      send_byte(8'h0D);
      check_idle($sformatf("r%0d_back", n));
   endtask

   initial begin
      reset    = 1'b1;
      received = 1'b0;
      data     = 8'h00;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      reset = 1'b0;

      mark_base();
      send_str("12|+|34|");
      finish_conv("add");
      send_str("|");
      check_idle("add_back");

      mark_base();
      send_str("n5|/|n0007|");
      finish_conv("div");
      send_str("|");

      mark_base();
      send_str("5n|||");
      finish_conv("late_n");
      send_str("|");
      check_idle("late_n_back");

      mark_base();
      send_str("200|*|5|");
      send_byte(8'h39);
      finish_conv("sat");
      send_str("|");
      check_idle("sat_back");

      apply_reset();
      mark_base();
      send_str("123<9|-|1|");
      finish_conv("bs");
      send_str("|");

      // Reset lands on the same edge as a byte event during conversion.
      send_str("77|+|88|");
      @(negedge clk);
      data     = 8'h37;
      received = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      received = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check_reset_state("midconv");
      reset = 1'b0;
      model_reset();
      repeat (6) @(negedge clk);
      mark_base();
      send_str("|+|3|");
      finish_conv("after_rst");
      send_str("|");

      for (int n = 0; n < 36; n++) begin
         if (n % 3 == 0) apply_reset();
         rand_expr(n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
